// File: rtl/divq_pkg.sv
// Shared types and defaults for the divider BCD formatter slice.
package divq_pkg;

    localparam int W_DEF  = 8;
    localparam int ND_DEF = 3;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_Q = 2'd1,
        CONV_R = 2'd2,
        HOLD   = 2'd3
    } divq_state_t;

    // Double-dabble digit correction applied before each shift.
    function automatic bcd_digit_t bcd_adjust(input bcd_digit_t d);
        if (d >= 4'd5) begin
            return d + 4'd3;
        end else begin
            return d;
        end
    endfunction

endpackage

// File: rtl/divq_bcd_formatter_if.sv
// Divider-side capture inputs and BCD result handshake of divq_bcd_formatter.
interface divq_bcd_formatter_if #(
    parameter int W  = 8,
    parameter int ND = 3
);
    logic            div_ready;
    logic [W-1:0]    quotient;
    logic [W-1:0]    remainder;
    logic            out_ready;
    logic [4*ND-1:0] bcd_q;
    logic [4*ND-1:0] bcd_r;
    logic            out_valid;
    logic            busy;
    logic            overrun;

    modport master (
        output div_ready, quotient, remainder, out_ready,
        input  bcd_q, bcd_r, out_valid, busy, overrun
    );

    modport slave (
        input  div_ready, quotient, remainder, out_ready,
        output bcd_q, bcd_r, out_valid, busy, overrun
    );
endinterface

// File: rtl/divq_bcd_formatter_dabble_step.sv
// One shift-and-add-3 step: correct every BCD digit, then shift in the operand MSB.
module bcd_dabble_step
    import divq_pkg::*;
#(
    parameter int ND = ND_DEF
) (
    input  logic [4*ND-1:0] acc,
    input  logic            in_bit,
    output logic [4*ND-1:0] acc_next
);

    logic [4*ND-1:0] adj_s;

    // Per-digit correction followed by the one-bit shift.
    always_comb begin
        adj_s = {(4*ND){1'b0}};
        for (int i = 0; i < ND; i++) begin
            adj_s[4*i +: 4] = bcd_adjust(acc[4*i +: 4]);
        end
        acc_next = (adj_s << 1) | {{(4*ND-1){1'b0}}, in_bit};
    end

endmodule

// File: rtl/divq_bcd_formatter.sv
// Captures divider results on READY rise and converts quotient then remainder to BCD.
// Optional dropped-completion flag: define OVERRUN_DETECT_EN.
module divq_bcd_formatter
    import divq_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int ND = ND_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    divq_bcd_formatter_if.slave  bus
);

    localparam int CW = $clog2(W + 1);
    localparam int BW = 4 * ND;

    divq_state_t   state_r, state_s;
    logic          prev_ready_r;
    logic          rise_s, accept_s, last_step_s, step_bit_s;
    logic [W-1:0]  shadow_q_r, shadow_r_r;
    logic [BW-1:0] acc_r, acc_step_s, bcd_q_r, bcd_r_r;
    logic [CW-1:0] cnt_r;
    logic          out_valid_r, busy_r, out_valid_s, busy_s;

    assign rise_s      = bus.div_ready & ~prev_ready_r;
    assign accept_s    = out_valid_r & bus.out_ready;
    assign last_step_s = (cnt_r == CW'(W - 1));

    // Both conversions share one step; pick which shadow feeds its LSB.
    always_comb begin
        if (state_r == CONV_R) begin
            step_bit_s = shadow_r_r[W-1];
        end else begin
            step_bit_s = shadow_q_r[W-1];
        end
    end

    bcd_dabble_step #(.ND(ND)) u_step (
        .acc      (acc_r),
        .in_bit   (step_bit_s),
        .acc_next (acc_step_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; a rise is only taken in IDLE or together with an accept.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (rise_s) state_s = CONV_Q;
                else        state_s = IDLE;
            end
            CONV_Q: begin
                if (last_step_s) state_s = CONV_R;
                else             state_s = CONV_Q;
            end
            CONV_R: begin
                if (last_step_s) state_s = HOLD;
                else             state_s = CONV_R;
            end
            HOLD: begin
                if (accept_s && rise_s) state_s = CONV_Q;
                else if (accept_s)      state_s = IDLE;
                else                    state_s = HOLD;
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so they can be registered.
    always_comb begin
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
        case (state_s)
            CONV_Q, CONV_R: busy_s      = 1'b1;
            HOLD:           out_valid_s = 1'b1;
            default: begin
                out_valid_s = 1'b0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // Datapath: READY history, operand shadows, accumulator, step counter, results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_ready_r <= 1'b1;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            shadow_q_r   <= {W{1'b0}};
            shadow_r_r   <= {W{1'b0}};
            acc_r        <= {BW{1'b0}};
            cnt_r        <= {CW{1'b0}};
            bcd_q_r      <= {BW{1'b0}};
            bcd_r_r      <= {BW{1'b0}};
        end else begin
            prev_ready_r <= bus.div_ready;
            out_valid_r  <= out_valid_s;
            busy_r       <= busy_s;
            case (state_r)
                IDLE, HOLD: begin
                    if (state_s == CONV_Q) begin
                        shadow_q_r <= bus.quotient;
                        shadow_r_r <= bus.remainder;
                        acc_r      <= {BW{1'b0}};
                        cnt_r      <= {CW{1'b0}};
                    end
                end
                CONV_Q: begin
                    shadow_q_r <= shadow_q_r << 1;
                    if (last_step_s) begin
                        bcd_q_r <= acc_step_s;
                        acc_r   <= {BW{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        acc_r <= acc_step_s;
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                CONV_R: begin
                    shadow_r_r <= shadow_r_r << 1;
                    acc_r      <= acc_step_s;
                    if (last_step_s) begin
                        bcd_r_r <= acc_step_s;
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign bus.bcd_q     = bcd_q_r;
    assign bus.bcd_r     = bcd_r_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;

`ifdef OVERRUN_DETECT_EN
    logic overrun_r, drop_s;

    assign drop_s = rise_s & (busy_r | (out_valid_r & ~bus.out_ready));

    // Sticky drop flag; cleared only by an accepted result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (accept_s) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign bus.overrun = overrun_r;
`else
    assign bus.overrun = 1'b0;
`endif

endmodule

// File: tb/tb_divq_bcd_formatter.sv
// Table-driven plus hand-sequenced checks of divq_bcd_formatter with a result scoreboard.
module tb_divq_bcd_formatter;

`ifdef OVERRUN_DETECT_EN
    localparam logic OVR_EN = 1'b1;
`else
    localparam logic OVR_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0]  q;
        logic [7:0]  r;
        logic [11:0] eq;
        logic [11:0] er;
    } vec_t;

    typedef struct packed {
        logic [11:0] q;
        logic [11:0] r;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t tbl[10];

    divq_bcd_formatter_if #(.W(8), .ND(3)) bus ();

    divq_bcd_formatter #(.W(8), .ND(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drop READY for two cycles, present operands, raise READY; returns after the capture edge.
    task automatic start_conv(input logic [7:0] q, input logic [7:0] r,
                              input logic [11:0] eq, input logic [11:0] er);
        exp_t e;
        bus.div_ready = 1'b0;
        tick();
        tick();
        bus.quotient  = q;
        bus.remainder = r;
        bus.div_ready = 1'b1;
        e.q = eq;
        e.r = er;
        sb.push_back(e);
        tick();
    endtask

    // From the capture edge: out_valid must stay low through edge 15 and rise at edge 16.
    task automatic wait_latency(input string name);
        repeat (15) tick();
        chk({name, "_valid_early"}, {31'd0, bus.out_valid}, 32'd0);
        tick();
        chk({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    endtask

    task automatic check_result(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({name, "_bcd_q"}, {20'd0, bus.bcd_q}, {20'd0, e.q});
            chk({name, "_bcd_r"}, {20'd0, bus.bcd_r}, {20'd0, e.r});
        end
    endtask

    task automatic accept(input string name);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({name, "_valid_after_accept"}, {31'd0, bus.out_valid}, 32'd0);
        chk({name, "_overrun_after_accept"}, {31'd0, bus.overrun}, 32'd0);
    endtask

    initial begin
        exp_t       dummy;
        logic [11:0] hq;
        logic [11:0] hr;

        tbl[0] = '{8'd15,  8'd1,   12'h015, 12'h001};
        tbl[1] = '{8'd255, 8'd0,   12'h255, 12'h000};
        tbl[2] = '{8'd37,  8'd9,   12'h037, 12'h009};
        tbl[3] = '{8'd100, 8'd99,  12'h100, 12'h099};
        tbl[4] = '{8'd0,   8'd0,   12'h000, 12'h000};
        tbl[5] = '{8'd99,  8'd100, 12'h099, 12'h100};
        tbl[6] = '{8'd128, 8'd127, 12'h128, 12'h127};
        tbl[7] = '{8'd9,   8'd10,  12'h009, 12'h010};
        tbl[8] = '{8'd200, 8'd55,  12'h200, 12'h055};
        tbl[9] = '{8'd7,   8'd3,   12'h007, 12'h003};

        bus.div_ready = 1'b1;
        bus.quotient  = 8'd0;
        bus.remainder = 8'd0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_bcd_q", {20'd0, bus.bcd_q}, 32'd0);
        chk("rst_bcd_r", {20'd0, bus.bcd_r}, 32'd0);
        chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
        rst = 1'b0;

        // READY already high after reset is not a completion.
        repeat (4) tick();
        chk("idle_ready_high_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("idle_ready_high_busy", {31'd0, bus.busy}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            start_conv(tbl[i].q, tbl[i].r, tbl[i].eq, tbl[i].er);
            chk("tbl_busy", {31'd0, bus.busy}, 32'd1);
            wait_latency("tbl");
            chk("tbl_busy_hold", {31'd0, bus.busy}, 32'd0);
            check_result("tbl");
            accept("tbl");
        end

        // Consumer always ready: out_valid lasts exactly one cycle.
        bus.out_ready = 1'b1;
        start_conv(8'd255, 8'd0, 12'h255, 12'h000);
        wait_latency("fastacc");
        check_result("fastacc");
        tick();
        chk("fastacc_one_cycle", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b0;

        // Backpressure: result and out_valid held for 20 cycles.
        start_conv(8'd200, 8'd55, 12'h200, 12'h055);
        wait_latency("bp");
        hq = bus.bcd_q;
        hr = bus.bcd_r;
        check_result("bp");
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("bp_valid_held", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_q_stable", {20'd0, bus.bcd_q}, {20'd0, hq});
            chk("bp_r_stable", {20'd0, bus.bcd_r}, {20'd0, hr});
        end
        accept("bp");
        chk("bp_idle_busy", {31'd0, bus.busy}, 32'd0);

        // Second completion at step 5 is dropped; operands in flight are unaffected.
        start_conv(8'd37, 8'd9, 12'h037, 12'h009);
        chk("drop_overrun_before", {31'd0, bus.overrun}, 32'd0);
        bus.div_ready = 1'b0;
        repeat (4) tick();
        bus.quotient  = 8'd200;
        bus.remainder = 8'd201;
        bus.div_ready = 1'b1;
        tick();
        chk("drop_busy", {31'd0, bus.busy}, 32'd1);
        chk("drop_overrun", {31'd0, bus.overrun}, {31'd0, OVR_EN});
        repeat (10) tick();
        chk("drop_valid_early", {31'd0, bus.out_valid}, 32'd0);
        tick();
        chk("drop_valid", {31'd0, bus.out_valid}, 32'd1);
        check_result("drop");
        chk("drop_overrun_hold", {31'd0, bus.overrun}, {31'd0, OVR_EN});
        accept("drop");
        repeat (3) tick();
        chk("drop_no_capture", {31'd0, bus.busy}, 32'd0);

        // Rise coincident with accept: straight back into conversion, no overrun.
        start_conv(8'd9, 8'd10, 12'h009, 12'h010);
        bus.div_ready = 1'b0;
        wait_latency("coin_first");
        check_result("coin_first");
        bus.quotient  = 8'd100;
        bus.remainder = 8'd99;
        bus.div_ready = 1'b1;
        bus.out_ready = 1'b1;
        dummy.q = 12'h100;
        dummy.r = 12'h099;
        sb.push_back(dummy);
        tick();
        bus.out_ready = 1'b0;
        chk("coin_valid_drop", {31'd0, bus.out_valid}, 32'd0);
        chk("coin_busy", {31'd0, bus.busy}, 32'd1);
        chk("coin_overrun", {31'd0, bus.overrun}, 32'd0);
        wait_latency("coin");
        check_result("coin");
        chk("coin_overrun_hold", {31'd0, bus.overrun}, 32'd0);
        accept("coin");

        // Reset during CONV_R discards the partial conversion.
        start_conv(8'd50, 8'd60, 12'h050, 12'h060);
        repeat (10) tick();
        chk("rstmid_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rstmid_busy0", {31'd0, bus.busy}, 32'd0);
        chk("rstmid_bcd_q", {20'd0, bus.bcd_q}, 32'd0);
        chk("rstmid_bcd_r", {20'd0, bus.bcd_r}, 32'd0);
        chk("rstmid_overrun", {31'd0, bus.overrun}, 32'd0);
        dummy = sb.pop_front();
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("rstmid_ignore_high", {31'd0, bus.busy}, 32'd0);
        start_conv(8'd7, 8'd3, 12'h007, 12'h003);
        wait_latency("rstmid_next");
        check_result("rstmid_next");
        accept("rstmid_next");

        chk("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/divq_bcd_formatter.md
Name: divq_bcd_formatter

Overview:
- Downstream consumer of the 8-bit restoring divider. Watches the divider's READY line and captures quotient and remainder when a division completes.
- Converts each value to packed BCD with a sequential shift-and-add-3 (double-dabble) engine and presents both results with a valid/ready handshake to the display/reporting logic.
- One conversion in flight at a time; results are held until accepted.

Parameters:
- W, 8, binary operand width (quotient and remainder).
- ND, 3, BCD digit count per operand; must satisfy 10^ND > 2^W - 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- div_ready  in  1  divider READY; a 0->1 transition marks a completed division.
- quotient  in  W  divider quotient, stable while div_ready=1.
- remainder  in  W  divider remainder, stable while div_ready=1.
- out_ready  in  1  consumer accepts the result.
- bcd_q  out  4*ND  packed BCD quotient, digit 0 in [3:0].
- bcd_r  out  4*ND  packed BCD remainder.
- out_valid  out  1  bcd_q/bcd_r are valid and held.
- busy  out  1  high in CONV_Q and CONV_R.
- overrun  out  1  sticky dropped-completion flag (see Optional Feature).

Behaviour:
- Reset values: bcd_q=0, bcd_r=0, out_valid=0, busy=0, overrun=0, FSM=IDLE. The div_ready history register resets to 1, so the divider's READY=1 in its idle state after reset is not treated as a completion.
- Completion event (rise): div_ready=1 sampled while the previous sample was 0.
- FSM states: IDLE, CONV_Q, CONV_R, HOLD.
  - IDLE: on rise, capture quotient and remainder into W-bit shadow registers, clear the BCD accumulator, go to CONV_Q.
  - CONV_Q: each edge adds 3 to every accumulator digit >= 5, then shifts {acc, shadow_q} left by 1. After W steps, write the accumulator to bcd_q, clear it, go to CONV_R.
  - CONV_R: same operation on shadow_r. After W steps, write the accumulator to bcd_r, go to HOLD.
  - HOLD: out_valid=1. bcd_q and bcd_r stay stable until out_valid & out_ready at a clock edge; then go to IDLE.
- Step counter: ceil(log2(W+1)) bits. Reset on entry to CONV_Q and on entry to CONV_R; terminal count is W-1.
- Latency: the capture edge is edge 0. out_valid rises after edge 2W (16 for W=8). bcd_q and bcd_r update only on the edge that enters HOLD.
- Simultaneous accept and rise in HOLD: the new operands are captured and the FSM goes straight to CONV_Q. out_valid drops on that edge; the event is not an overrun.
- A rise in CONV_Q or CONV_R, or in HOLD without accept, is dropped. The operands in flight are never disturbed.
- out_valid never depends combinationally on out_ready.
- Divisor-zero results (quotient 255) are converted normally.
- Reset mid-operation: immediate return to reset values; the partial conversion is discarded. A completion already high at reset release is ignored until div_ready falls and rises again.

Optional Feature:
- Macro OVERRUN_DETECT_EN.
- Defined: overrun sets on any dropped rise, per the Behaviour rules. It stays set until reset or the next accepted handshake (out_valid & out_ready), after which it reads 0.
- Undefined: the overrun port is tied to 0 and no detection logic is built. Drop behaviour is otherwise identical.

Decomposition:
- Shared package divq_pkg: the FSM state enum (IDLE, CONV_Q, CONV_R, HOLD), the constants W_DEF=8 and ND_DEF=3, and a BCD digit typedef (logic [3:0]).
- Sub-module bcd_dabble_step: combinational, ND-digit add-3-if-≥5 on the accumulator plus a 1-bit left shift taking the MSB of the operand shadow. Instantiated once and shared by CONV_Q and CONV_R.
- The FSM, counter and registers live in the top module.

Test Plan:
- Reset, then hold div_ready=1 -> no capture, out_valid=0, busy=0. Drop div_ready for 2 cycles, raise it with quotient=15, remainder=1 (211/14) -> out_valid rises after edge 16; bcd_q=12'h015, bcd_r=12'h001.
- quotient=255, remainder=0 with out_ready=1 -> bcd_q=12'h255, bcd_r=12'h000; out_valid high for exactly 1 cycle.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> outputs stable and out_valid stays high. Raise out_ready -> handshake on the next edge, then IDLE.
- Second rise at conversion step 5 -> first result unchanged (q=37, r=9 gives 12'h037, 12'h009). overrun=1 if OVERRUN_DETECT_EN, else 0. overrun clears after the accept.
- Rise coincident with accept in HOLD -> new operands (q=100, r=99) captured, no overrun, result 12'h100, 12'h099 after 16 edges.
- Assert rst during CONV_R -> all outputs return to 0 immediately. The next completion converts correctly (q=7, r=3 gives 12'h007, 12'h003).
